// File: rtl/branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_unit
// Description : Evaluates SPARC v8 integer branch/trap conditions (Bicc, Ticc),
//               classifies SAVE/RESTORE, tracks annulled delay slots and
//               presents one registered result per accepted instruction over
//               a valid/ready handshake.
//               Optional macro BCU_WINDOW_CHECK_EN enables register-window
//               overflow/underflow checking of SAVE/RESTORE against WIM/CWP.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_unit #(
    parameter int NWINDOWS = 8,
    parameter int WIN_W    = 5
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Flush,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [31:0]         IR,
    input  logic                N,
    input  logic                Z,
    input  logic                V,
    input  logic                C,
    input  logic [WIN_W-1:0]    CWP,
    input  logic [NWINDOWS-1:0] WIM,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic                Cond,
    output logic                Annul,
    output logic                Squash,
    output logic [1:0]          Kind,
    output logic                Win_Ovf,
    output logic                Win_Unf
);

    // Instruction classes as reported on Kind
    localparam logic [1:0] c_kind_other = 2'b00;
    localparam logic [1:0] c_kind_bicc  = 2'b01;
    localparam logic [1:0] c_kind_ticc  = 2'b10;
    localparam logic [1:0] c_kind_win   = 2'b11;

    // Delay-slot tracking states
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_annul = 1'b1;

    // Registered result and state
    logic       out_valid_q, out_valid_d;
    logic       cond_q, cond_d;
    logic       annul_q, annul_d;
    logic       squash_q, squash_d;
    logic [1:0] kind_q, kind_d;
    logic       win_ovf_q, win_ovf_d;
    logic       win_unf_q, win_unf_d;
    logic [0:0] state_q, state_d;

    // Decode / evaluation wires
    logic       w_accept;
    logic       w_is_bicc;
    logic       w_is_ticc;
    logic       w_is_save;
    logic       w_is_restore;
    logic       w_cc_base;
    logic       w_cc_true;
    logic       w_squash_slot;
    logic       w_save_ovf;
    logic       w_restore_unf;
    logic       w_cwp_ok;
    logic [1:0] w_kind;
    logic       w_cond_raw;
    logic       w_annul_raw;
    logic       w_ovf_raw;
    logic       w_unf_raw;
    logic       w_res_cond;
    logic       w_res_annul;
    logic       w_res_ovf;
    logic       w_res_unf;

    // Handshake: a new instruction can enter only when the output slot frees up
    always_comb begin
        In_Ready = (!out_valid_q || Out_Ready) && !Flush;
        w_accept = In_Valid && In_Ready;
    end

    // Instruction class decode from op / op2 / op3 fields
    always_comb begin
        w_is_bicc    = (IR[31:30] == 2'b00) && (IR[24:22] == 3'b010);
        w_is_ticc    = (IR[31:30] == 2'b10) && (IR[24:19] == 6'b111010);
        w_is_save    = (IR[31:30] == 2'b10) && (IR[24:19] == 6'b111100);
        w_is_restore = (IR[31:30] == 2'b10) && (IR[24:19] == 6'b111101);
    end

    // Condition evaluation: IR[27:25] picks the test, IR[28] inverts it
    always_comb begin
        w_cc_base = 1'b0;
        case (IR[27:25])
            3'b000:  w_cc_base = 1'b0;
            3'b001:  w_cc_base = Z;
            3'b010:  w_cc_base = Z | (N ^ V);
            3'b011:  w_cc_base = N ^ V;
            3'b100:  w_cc_base = C | Z;
            3'b101:  w_cc_base = C;
            3'b110:  w_cc_base = N;
            default: w_cc_base = V;
        endcase
        w_cc_true = IR[28] ? ~w_cc_base : w_cc_base;
    end

`ifdef BCU_WINDOW_CHECK_EN
    localparam logic [NWINDOWS-1:0] c_one_hot = {{(NWINDOWS-1){1'b0}}, 1'b1};

    int w_cwp_int;
    int w_save_idx;
    int w_restore_idx;

    // Neighbouring-window lookup in WIM with modular wrap at both ends
    always_comb begin
        w_cwp_int     = {{(32-WIN_W){1'b0}}, CWP};
        w_cwp_ok      = (w_cwp_int < NWINDOWS);
        w_save_idx    = (w_cwp_int == 0) ? (NWINDOWS - 1) : (w_cwp_int - 1);
        w_restore_idx = (w_cwp_int == NWINDOWS - 1) ? 0 : (w_cwp_int + 1);
        w_save_ovf    = w_cwp_ok && (|(WIM & (c_one_hot << w_save_idx)));
        w_restore_unf = w_cwp_ok && (|(WIM & (c_one_hot << w_restore_idx)));
    end

    logic w_unused_ok;
    assign w_unused_ok = ^IR[18:0];
`else
    // Window checking disabled: SAVE/RESTORE are always permitted
    always_comb begin
        w_cwp_ok      = 1'b1;
        w_save_ovf    = 1'b0;
        w_restore_unf = 1'b0;
    end

    logic w_unused_ok;
    assign w_unused_ok = ^{IR[18:0], CWP, WIM};
`endif

    // Unsquashed result of the instruction currently on IR
    always_comb begin
        w_kind      = c_kind_other;
        w_cond_raw  = 1'b1;
        w_annul_raw = 1'b0;
        w_ovf_raw   = 1'b0;
        w_unf_raw   = 1'b0;
        if (w_is_bicc) begin
            w_kind      = c_kind_bicc;
            w_cond_raw  = w_cc_true;
            // Annulling BA always kills its slot; conditional ones only when untaken
            w_annul_raw = IR[29] && (!w_cc_true || (IR[28:25] == 4'b1000));
        end else if (w_is_ticc) begin
            w_kind      = c_kind_ticc;
            w_cond_raw  = w_cc_true;
        end else if (w_is_save) begin
            w_kind      = c_kind_win;
            w_ovf_raw   = w_save_ovf;
            w_cond_raw  = w_cwp_ok && !w_save_ovf;
        end else if (w_is_restore) begin
            w_kind      = c_kind_win;
            w_unf_raw   = w_restore_unf;
            w_cond_raw  = w_cwp_ok && !w_restore_unf;
        end
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a squashed slot never re-arms the annul state
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = c_st_idle;
        end else if (w_accept) begin
            if (state_q == c_st_annul) begin
                state_d = c_st_idle;
            end else if (w_is_bicc && w_annul_raw) begin
                state_d = c_st_annul;
            end
        end
    end

    // FSM outputs: the next accepted instruction is the annulled delay slot
    always_comb begin
        w_squash_slot = (state_q == c_st_annul);
        w_res_cond    = w_squash_slot ? 1'b0 : w_cond_raw;
        w_res_annul   = w_squash_slot ? 1'b0 : w_annul_raw;
        w_res_ovf     = w_squash_slot ? 1'b0 : w_ovf_raw;
        w_res_unf     = w_squash_slot ? 1'b0 : w_unf_raw;
    end

    // Result slot next value: load on accept, drain on consume, drop on flush
    always_comb begin
        out_valid_d = out_valid_q;
        cond_d      = cond_q;
        annul_d     = annul_q;
        squash_d    = squash_q;
        kind_d      = kind_q;
        win_ovf_d   = win_ovf_q;
        win_unf_d   = win_unf_q;
        if (Flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            cond_d      = w_res_cond;
            annul_d     = w_res_annul;
            squash_d    = w_squash_slot;
            kind_d      = w_kind;
            win_ovf_d   = w_res_ovf;
            win_unf_d   = w_res_unf;
        end else if (Out_Ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Result slot registers
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            cond_q      <= 1'b0;
            annul_q     <= 1'b0;
            squash_q    <= 1'b0;
            kind_q      <= c_kind_other;
            win_ovf_q   <= 1'b0;
            win_unf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            cond_q      <= cond_d;
            annul_q     <= annul_d;
            squash_q    <= squash_d;
            kind_q      <= kind_d;
            win_ovf_q   <= win_ovf_d;
            win_unf_q   <= win_unf_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign Cond      = cond_q;
    assign Annul     = annul_q;
    assign Squash    = squash_q;
    assign Kind      = kind_q;
    assign Win_Ovf   = win_ovf_q;
    assign Win_Unf   = win_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_cond_unit
// Description : Scoreboard bench for branch_cond_unit: directed scenarios plus
//               randomized traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_cond_unit;

    localparam int NW = 8;

    typedef struct packed {
        logic [1:0] kind;
        logic       cond;
        logic       annul;
        logic       squash;
        logic       ovf;
        logic       unf;
    } res_t;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Flush = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [31:0] IR = 32'h0;
    logic        N = 1'b0, Z = 1'b0, V = 1'b0, C = 1'b0;
    logic [4:0]  CWP = 5'd0;
    logic [7:0]  WIM = 8'h0;
    logic        Out_Valid;
    logic        Out_Ready = 1'b1;
    logic        Cond, Annul, Squash, Win_Ovf, Win_Unf;
    logic [1:0]  Kind;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   started = 1'b0;
    bit   m_in_slot = 1'b0;   // next accepted instruction is an annulled slot

    always #5 Clock = ~Clock;

    branch_cond_unit #(.NWINDOWS(NW), .WIN_W(5)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .IR(IR),
        .N(N), .Z(Z), .V(V), .C(C), .CWP(CWP), .WIM(WIM),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Cond(Cond), .Annul(Annul), .Squash(Squash), .Kind(Kind),
        .Win_Ovf(Win_Ovf), .Win_Unf(Win_Unf)
    );

    // SPARC integer condition codes, written as the architectural predicates
    function automatic logic eval_cond(input logic [3:0] cc, input logic n, z, v, c);
        logic lt;
        logic r;
        lt = (n != v);          // signed less-than
        case (cc)
            4'h8: r = 1'b1;           4'h0: r = 1'b0;
            4'h9: r = !z;             4'h1: r = z;
            4'hA: r = !(z || lt);     4'h2: r = z || lt;
            4'hB: r = !lt;            4'h3: r = lt;
            4'hC: r = !(c || z);      4'h4: r = c || z;
            4'hD: r = !c;             4'h5: r = c;
            4'hE: r = !n;             4'h6: r = n;
            4'hF: r = !v;             default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic wim_bit(input logic [7:0] wim, input int idx);
        logic [7:0] sh;
        sh = wim >> idx;
        return sh[0];
    endfunction

    function automatic res_t ref_model(input logic [31:0] ir, input logic n, z, v, c,
                                       input logic [4:0] cwp, input logic [7:0] wim);
        res_t r;
        int   w;
        logic [5:0] op3;
        r = '0;
        r.cond = 1'b1;
        op3 = ir[24:19];
        w = int'(cwp);
        if (ir[31:30] == 2'b00 && ir[24:22] == 3'b010) begin
            r.kind  = 2'b01;
            r.cond  = eval_cond(ir[28:25], n, z, v, c);
            r.annul = ir[29] && (!r.cond || ir[28:25] == 4'h8);
        end else if (ir[31:30] == 2'b10 && op3 == 6'h3A) begin
            r.kind = 2'b10;
            r.cond = eval_cond(ir[28:25], n, z, v, c);
        end else if (ir[31:30] == 2'b10 && (op3 == 6'h3C || op3 == 6'h3D)) begin
            r.kind = 2'b11;
`ifdef BCU_WINDOW_CHECK_EN
            if (w >= NW) begin
                r.cond = 1'b0;
            end else if (op3 == 6'h3C) begin
                r.ovf  = wim_bit(wim, (w + NW - 1) % NW);
                r.cond = !r.ovf;
            end else begin
                r.unf  = wim_bit(wim, (w + 1) % NW);
                r.cond = !r.unf;
            end
`else
            if (w < 0) r.cond = 1'b0;   // never true; window inputs are ignored here
`endif
        end
        return r;
    endfunction

    // Monitor: compare the presented result every cycle it is valid (also
    // proves stability under backpressure) and retire it when consumed.
    always @(negedge Clock) begin
        if (started) begin
            res_t got;
            checks++;
            if (Out_Valid !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL out_valid: got %b expected %b", Out_Valid, (sb.size() != 0));
            end
            if (Out_Valid === 1'b1 && sb.size() != 0) begin
                got = {Kind, Cond, Annul, Squash, Win_Ovf, Win_Unf};
                checks++;
                if (got !== sb[0]) begin
                    errors++;
                    $display("FAIL result: got kind=%b cond=%b annul=%b squash=%b ovf=%b unf=%b required kind=%b cond=%b annul=%b squash=%b ovf=%b unf=%b",
                             got.kind, got.cond, got.annul, got.squash, got.ovf, got.unf,
                             sb[0].kind, sb[0].cond, sb[0].annul, sb[0].squash, sb[0].ovf, sb[0].unf);
                end
            end
            if (sb.size() != 0 && Out_Ready === 1'b1) void'(sb.pop_front());
        end
    end

    // Model step for the cycle whose inputs are now stable (runs after monitor)
    task automatic model_step();
        logic exp_ready;
        res_t r;
        exp_ready = (sb.size() == 0) && !Flush;
        if (started) begin
            checks++;
            if (In_Ready !== exp_ready) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b", In_Ready, exp_ready);
            end
        end
        if (!Reset_n || Flush) begin
            sb.delete();
            m_in_slot = 1'b0;
        end else if (In_Valid && exp_ready) begin
            r = ref_model(IR, N, Z, V, C, CWP, WIM);
            if (m_in_slot) begin
                r.cond = 1'b0; r.annul = 1'b0; r.ovf = 1'b0; r.unf = 1'b0;
                r.squash = 1'b1;
                m_in_slot = 1'b0;
            end else if (r.kind == 2'b01 && r.annul) begin
                m_in_slot = 1'b1;
            end
            sb.push_back(r);
        end
    endtask

    task automatic cyc(input logic rstn, input logic fl, input logic iv,
                       input logic [31:0] ir, input logic [3:0] nzvc,
                       input logic [4:0] cwp, input logic [7:0] wim, input logic ordy);
        @(posedge Clock);
        #1;
        Reset_n = rstn; Flush = fl; In_Valid = iv; IR = ir;
        {N, Z, V, C} = nzvc; CWP = cwp; WIM = wim; Out_Ready = ordy;
        @(negedge Clock);
        #1;
        model_step();
    endtask

    task automatic send(input logic [31:0] ir, input logic [3:0] nzvc, input logic ordy);
        cyc(1'b1, 1'b0, 1'b1, ir, nzvc, 5'd0, 8'h00, ordy);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 5'd0, 8'h00, ordy);
    endtask

    function automatic logic [31:0] gen_ir();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0, 1: begin x[31:30] = 2'b00; x[24:22] = 3'b010; end
            2:    begin x[31:30] = 2'b10; x[24:19] = 6'h3A; end
            3:    begin x[31:30] = 2'b10; x[24:19] = 6'h3C; end
            4:    begin x[31:30] = 2'b10; x[24:19] = 6'h3D; end
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 5'd0, 8'h00, 1'b1);
        started = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 5'd0, 8'h00, 1'b1);
        idle(1'b1);
        checks++;
        if ({Out_Valid, Cond, Annul, Squash, Win_Ovf, Win_Unf, Kind} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b required 00000000",
                     {Out_Valid, Cond, Annul, Squash, Win_Ovf, Win_Unf, Kind});
        end

        // BE taken, then BA,a followed by its squashed slot, then a normal branch
        send(32'h0280_0000, 4'b0100, 1'b1);
        send(32'h3080_0000, 4'b0000, 1'b1);
        send(32'h0100_0000, 4'b0000, 1'b1);
        send(32'h0280_0000, 4'b0100, 1'b1);
        idle(1'b1);

        // Window wrap cases
        cyc(1'b1, 1'b0, 1'b1, 32'h81E0_0000, 4'h0, 5'd0, 8'h80, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h81E8_0000, 4'h0, 5'd7, 8'h01, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h81E0_0000, 4'h0, 5'd9, 8'hFF, 1'b1);

        // Overflow-set conditions (both the literal word and a Bicc-encoded BVS)
        send(32'h0F00_0000, 4'b0010, 1'b1);
        send(32'h0F00_0000, 4'b0000, 1'b1);
        send(32'h0E80_0000, 4'b0010, 1'b1);
        send(32'h0E80_0000, 4'b0000, 1'b1);
        idle(1'b1);

        // Backpressure for three cycles, then same-cycle handoff
        send(32'h0280_0000, 4'b0100, 1'b0);
        repeat (3) send(32'h0A80_0000, 4'b1000, 1'b0);
        send(32'h0A80_0000, 4'b1000, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset while in annul state with a held result
        send(32'h3080_0000, 4'b0000, 1'b0);
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 5'd0, 8'h00, 1'b0);
        send(32'h0280_0000, 4'b0100, 1'b1);
        idle(1'b1);

        // Flush in the same situation
        send(32'h3080_0000, 4'b0000, 1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0280_0000, 4'h0, 5'd0, 8'h00, 1'b0);
        send(32'h0280_0000, 4'b0100, 1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 3) != 0), gen_ir(), 4'($urandom),
                5'($urandom_range(0, 9)), 8'($urandom), ($urandom_range(0, 2) != 0));
        end

        repeat (3) idle(1'b1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
